// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } state_e;

   typedef logic port_t;
   localparam port_t PORT_F = 1'b0;
   localparam port_t PORT_M = 1'b1;

   typedef struct packed {
      logic              mode;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
   } req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and downstream memory signals around the arbiter.
// master: the requesters plus the memory side; slave: the arbiter itself.
interface mem_port_arbiter_if;
   import mem_arb_pkg::*;

   logic              f_req_en;
   logic              f_req_mode;
   logic [ADDR_W-1:0] f_req_addr;
   logic [DATA_W-1:0] f_req_wdata;
   logic [STRB_W-1:0] f_req_wstrb;
   logic              f_resp_en;
   logic [DATA_W-1:0] f_resp_data;

   logic              m_req_en;
   logic              m_req_mode;
   logic [ADDR_W-1:0] m_req_addr;
   logic [DATA_W-1:0] m_req_wdata;
   logic [STRB_W-1:0] m_req_wstrb;
   logic              m_resp_en;
   logic [DATA_W-1:0] m_resp_data;

   logic              request_enable;
   logic              req_mode;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [STRB_W-1:0] req_wstrb;
   logic              response_enable;
   logic [DATA_W-1:0] resp_data;

   logic              busy;

   modport master (
      output f_req_en, f_req_mode, f_req_addr, f_req_wdata, f_req_wstrb,
      input  f_resp_en, f_resp_data,
      output m_req_en, m_req_mode, m_req_addr, m_req_wdata, m_req_wstrb,
      input  m_resp_en, m_resp_data,
      input  request_enable, req_mode, req_addr, req_wdata, req_wstrb,
      output response_enable, resp_data,
      input  busy
   );

   modport slave (
      input  f_req_en, f_req_mode, f_req_addr, f_req_wdata, f_req_wstrb,
      output f_resp_en, f_resp_data,
      input  m_req_en, m_req_mode, m_req_addr, m_req_wdata, m_req_wstrb,
      output m_resp_en, m_resp_data,
      output request_enable, req_mode, req_addr, req_wdata, req_wstrb,
      input  response_enable, resp_data,
      output busy
   );

endinterface

// File: rtl/mem_arb_pending_slot.sv
// One-deep pending request holder for a single requester port.
// A request is refused while the slot is already full or while this port's
// own transaction is in flight (block_i); a refused request leaves the
// stored fields untouched. avail_o/req_o also expose a request captured in
// the current cycle so it can be granted on the same edge.
module mem_arb_pending_slot
   import mem_arb_pkg::*;
(
   input  logic clk,
   input  logic rstn,
   input  logic req_en_i,
   input  req_t req_i,
   input  logic block_i,
   input  logic clr_i,
   output logic avail_o,
   output req_t req_o,
   output logic pend_o
);

   logic pend_q, pend_d;
   req_t req_q, req_d;
   logic cap;

   assign cap     = req_en_i && !pend_q && !block_i;
   assign avail_o = pend_q || cap;
   assign req_o   = cap ? req_i : req_q;
   assign pend_o  = pend_q;

   // Next state: set on capture, cleared when the arbiter grants this slot.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      req_d  = req_q;
      pend_d = (pend_q || cap) && !clr_i;
      if (cap) begin
         req_d = req_i;
      end
   end

   // Slot registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pend_q <= 1'b0;
         // NOTE: the stored payload is reset too, so nothing stale can leak onto req_* after reset.
         req_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments for all sequential state.
         pend_q <= pend_d;
         req_q  <= req_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between fetch (F) and data (M) requesters.
// One downstream transaction in flight, one pending request per port,
// responses routed back to the owner. Priority is fixed M-over-F unless
// MEM_ARB_RR_EN is defined, which selects round-robin on contention.
module mem_port_arbiter
   import mem_arb_pkg::*;
(
   input logic               clk,
   input logic               rstn,
   mem_port_arbiter_if.slave bus
);

   state_e            state_q;
   port_t             owner_q;
   req_t              req_q;
   logic              request_enable_q;
   logic              f_resp_en_q, m_resp_en_q;
   logic [DATA_W-1:0] f_resp_data_q, m_resp_data_q;
`ifdef MEM_ARB_RR_EN
   port_t             rr_last_q;
`endif

   req_t  f_in, m_in, f_req, m_req, grant_req;
   logic  f_avail, m_avail, f_pend, m_pend;
   logic  in_flight, grant_ok, grant_any, f_clr, m_clr;
   port_t grant_port;

   assign in_flight = (state_q != IDLE);

   assign f_in = '{mode: bus.f_req_mode, addr: bus.f_req_addr,
                   wdata: bus.f_req_wdata, wstrb: bus.f_req_wstrb};
   assign m_in = '{mode: bus.m_req_mode, addr: bus.m_req_addr,
                   wdata: bus.m_req_wdata, wstrb: bus.m_req_wstrb};

   mem_arb_pending_slot u_slot_f (
      .clk     (clk),
      .rstn    (rstn),
      .req_en_i(bus.f_req_en),
      .req_i   (f_in),
      .block_i (in_flight && (owner_q == PORT_F)),
      .clr_i   (f_clr),
      .avail_o (f_avail),
      .req_o   (f_req),
      .pend_o  (f_pend)
   );

   mem_arb_pending_slot u_slot_m (
      .clk     (clk),
      .rstn    (rstn),
      .req_en_i(bus.m_req_en),
      .req_i   (m_in),
      .block_i (in_flight && (owner_q == PORT_M)),
      .clr_i   (m_clr),
      .avail_o (m_avail),
      .req_o   (m_req),
      .pend_o  (m_pend)
   );

   // Grant selection: legal in IDLE, or in WAIT on the edge the response lands.
   always_comb begin
      grant_ok  = (state_q == IDLE) || ((state_q == WAIT) && bus.response_enable);
      grant_any = f_avail || m_avail;
`ifdef MEM_ARB_RR_EN
      if (f_avail && m_avail) begin
         grant_port = (rr_last_q == PORT_M) ? PORT_F : PORT_M;
      end else begin
         grant_port = m_avail ? PORT_M : PORT_F;
      end
`else
      grant_port = m_avail ? PORT_M : PORT_F;
`endif
      grant_req = (grant_port == PORT_M) ? m_req : f_req;
      f_clr     = grant_ok && grant_any && (grant_port == PORT_F);
      m_clr     = grant_ok && grant_any && (grant_port == PORT_M);
   end

   // Transaction FSM with registered downstream and response outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q          <= IDLE;
         owner_q          <= PORT_F;
         req_q            <= '0;
         request_enable_q <= 1'b0;
         f_resp_en_q      <= 1'b0;
         m_resp_en_q      <= 1'b0;
         f_resp_data_q    <= '0;
         m_resp_data_q    <= '0;
`ifdef MEM_ARB_RR_EN
         rr_last_q        <= PORT_M;
`endif
      end else begin
         request_enable_q <= 1'b0;
         f_resp_en_q      <= 1'b0;
         m_resp_en_q      <= 1'b0;

         if (grant_ok && grant_any) begin
            req_q            <= grant_req;
            owner_q          <= grant_port;
            request_enable_q <= 1'b1;
`ifdef MEM_ARB_RR_EN
            rr_last_q        <= grant_port;
`endif
         end

         case (state_q)
            IDLE: begin
               if (grant_any) state_q <= ISSUE;
            end
            ISSUE: begin
               state_q <= WAIT;
            end
            WAIT: begin
               if (bus.response_enable) begin
                  if (owner_q == PORT_M) begin
                     m_resp_en_q   <= 1'b1;
                     m_resp_data_q <= bus.resp_data;
                  end else begin
                     f_resp_en_q   <= 1'b1;
                     f_resp_data_q <= bus.resp_data;
                  end
                  state_q <= grant_any ? ISSUE : IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.request_enable = request_enable_q;
   assign bus.req_mode       = req_q.mode;
   assign bus.req_addr       = req_q.addr;
   assign bus.req_wdata      = req_q.wdata;
   assign bus.req_wstrb      = req_q.wstrb;
   assign bus.f_resp_en      = f_resp_en_q;
   assign bus.f_resp_data    = f_resp_data_q;
   assign bus.m_resp_en      = m_resp_en_q;
   assign bus.m_resp_data    = m_resp_data_q;
   assign bus.busy           = in_flight || f_pend || m_pend;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Directed scenarios check fixed
// expectations; a randomized run is compared each cycle against a
// transaction-level reference model. Define MEM_ARB_RR_EN to build and
// check the round-robin variant.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic clk;
   logic rstn;
   int   checks;
   int   failures;

   mem_port_arbiter_if bus ();

   mem_port_arbiter dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model (transaction level) ----------------
   // Port index 0 = F, 1 = M.
   bit                queued[2];     // accepted and waiting for a grant
   req_t              held[2];       // the accepted request fields
   int                cur;           // port whose transaction is downstream, -1 none
   int                since;         // edges passed since that transaction's grant
   int                rr_last;
   bit                e_reqen;
   req_t              e_req;
   bit                e_resp_en[2];
   logic [DATA_W-1:0] e_resp_data[2];

   function automatic bit in_en(int x);
      return (x == 0) ? bus.f_req_en : bus.m_req_en;
   endfunction

   function automatic req_t in_req(int x);
      req_t r;
      if (x == 0) r = '{bus.f_req_mode, bus.f_req_addr, bus.f_req_wdata, bus.f_req_wstrb};
      else        r = '{bus.m_req_mode, bus.m_req_addr, bus.m_req_wdata, bus.m_req_wstrb};
      return r;
   endfunction

   function automatic bit e_busy();
      return (cur >= 0) || queued[0] || queued[1];
   endfunction

   function automatic int pick();
      if (queued[0] && queued[1]) begin
`ifdef MEM_ARB_RR_EN
         return (rr_last == 1) ? 0 : 1;
`else
         return 1;
`endif
      end
      if (queued[1]) return 1;
      if (queued[0]) return 0;
      return -1;
   endfunction

   task automatic model_reset();
      queued  = '{0, 0};
      held    = '{'0, '0};
      cur     = -1;
      since   = 0;
      rr_last = 1;
      e_reqen = 0;
      e_req   = '0;
      e_resp_en   = '{0, 0};
      e_resp_data = '{'0, '0};
   endtask

   // One clock edge of the rules: accept requests, deliver a response,
   // hand the port to the next waiting requester.
   task automatic model_step();
      bit accept[2];
      bit respond;
      int g;
      e_reqen   = 0;
      e_resp_en = '{0, 0};
      for (int x = 0; x < 2; x++)
         accept[x] = in_en(x) && !queued[x] && (cur != x);
      // The cycle carrying request_enable cannot also carry its response.
      respond = (cur >= 0) && (since >= 1) && bus.response_enable;
      for (int x = 0; x < 2; x++)
         if (accept[x]) begin
            queued[x] = 1;
            held[x]   = in_req(x);
         end
      if (respond) begin
         e_resp_en[cur]   = 1;
         e_resp_data[cur] = bus.resp_data;
      end
      if (cur >= 0 && !respond) since++;
      if (cur < 0 || respond) begin
         g = pick();
         if (g >= 0) begin
            e_reqen   = 1;
            e_req     = held[g];
            queued[g] = 0;
            cur       = g;
            since     = 0;
            rr_last   = g;
         end else begin
            cur = -1;
         end
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic drive_idle();
      bus.f_req_en = 0; bus.f_req_mode = 0; bus.f_req_addr = '0;
      bus.f_req_wdata = '0; bus.f_req_wstrb = '0;
      bus.m_req_en = 0; bus.m_req_mode = 0; bus.m_req_addr = '0;
      bus.m_req_wdata = '0; bus.m_req_wstrb = '0;
      bus.response_enable = 0; bus.resp_data = '0;
   endtask

   task automatic set_f(input logic mode, input logic [ADDR_W-1:0] addr);
      bus.f_req_en = 1; bus.f_req_mode = mode; bus.f_req_addr = addr;
      bus.f_req_wdata = 32'h0F0F_0000 ^ addr; bus.f_req_wstrb = 4'hF;
   endtask

   task automatic set_m(input logic mode, input logic [ADDR_W-1:0] addr,
                        input logic [STRB_W-1:0] strb);
      bus.m_req_en = 1; bus.m_req_mode = mode; bus.m_req_addr = addr;
      bus.m_req_wdata = 32'h5555_AAAA; bus.m_req_wstrb = strb;
   endtask

   function automatic logic [127:0] all_outputs();
      return {bus.request_enable, bus.req_mode, bus.req_addr, bus.req_wdata, bus.req_wstrb,
              bus.f_resp_en, bus.f_resp_data, bus.m_resp_en, bus.m_resp_data, bus.busy};
   endfunction

   // Let every open transaction finish; response_enable held high is ignored outside WAIT.
   task automatic drain();
      int n;
      drive_idle();
      bus.response_enable = 1;
      n = 0;
      while ((bus.busy || e_busy()) && n < 60) begin
         tick();
         n++;
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL drain_timeout: busy=%b after %0d cycles, required 0", bus.busy, n);
      end
      drive_idle();
      tick();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rstn = 0;
      drive_idle();
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (all_outputs() !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got %h required 0", all_outputs());
      end
      rstn = 1;
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.request_enable !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle: busy=%b request_enable=%b required 0 0",
                  bus.busy, bus.request_enable);
      end
   endtask

   task automatic test_single_fetch();
      set_f(1'b0, 32'h8000_0000);
      tick();                                  // t0+1
      bus.f_req_en = 0;
      checks++;
      if (bus.request_enable !== 1'b1 || bus.req_addr !== 32'h8000_0000 || bus.req_mode !== 1'b0) begin
         failures++;
         $display("FAIL single_issue: en=%b addr=%h mode=%b required 1 80000000 0",
                  bus.request_enable, bus.req_addr, bus.req_mode);
      end
      tick();                                  // t0+2
      checks++;
      if (bus.request_enable !== 1'b0 || bus.req_addr !== 32'h8000_0000) begin
         failures++;
         $display("FAIL single_pulse: en=%b addr=%h required 0 80000000",
                  bus.request_enable, bus.req_addr);
      end
      tick();                                  // t0+3
      tick();                                  // t0+4
      bus.response_enable = 1;
      bus.resp_data       = 32'hDEAD_BEEF;
      tick();                                  // t0+5
      bus.response_enable = 0;
      checks++;
      if (bus.f_resp_en !== 1'b1 || bus.f_resp_data !== 32'hDEAD_BEEF || bus.m_resp_en !== 1'b0) begin
         failures++;
         $display("FAIL single_resp: f_en=%b f_data=%h m_en=%b required 1 deadbeef 0",
                  bus.f_resp_en, bus.f_resp_data, bus.m_resp_en);
      end
      tick();
      checks++;
      if (bus.f_resp_en !== 1'b0 || bus.f_resp_data !== 32'hDEAD_BEEF || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL single_hold: f_en=%b f_data=%h busy=%b required 0 deadbeef 0",
                  bus.f_resp_en, bus.f_resp_data, bus.busy);
      end
   endtask

   // Both ports at once: M first (the last grant went to F, so this holds for
   // round-robin too), then F straight after M's response.
   task automatic test_simultaneous();
      set_f(1'b0, 32'h0000_0100);
      set_m(1'b1, 32'h0000_0200, 4'b0011);
      tick();
      drive_idle();
      checks++;
      if (bus.request_enable !== 1'b1 || bus.req_addr !== 32'h0000_0200 || bus.req_mode !== 1'b1 ||
          bus.req_wstrb !== 4'b0011 || bus.req_wdata !== 32'h5555_AAAA || bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL simul_first: en=%b addr=%h mode=%b strb=%h busy=%b required 1 00000200 1 3 1",
                  bus.request_enable, bus.req_addr, bus.req_mode, bus.req_wstrb, bus.busy);
      end
      tick();
      bus.response_enable = 1;
      bus.resp_data       = 32'h1234_5678;
      tick();
      bus.response_enable = 0;
      checks++;
      if (bus.m_resp_en !== 1'b1 || bus.m_resp_data !== 32'h1234_5678 || bus.f_resp_en !== 1'b0 ||
          bus.request_enable !== 1'b1 || bus.req_addr !== 32'h0000_0100 || bus.req_mode !== 1'b0) begin
         failures++;
         $display("FAIL simul_second: m_en=%b m_data=%h f_en=%b en=%b addr=%h required 1 12345678 0 1 00000100",
                  bus.m_resp_en, bus.m_resp_data, bus.f_resp_en, bus.request_enable, bus.req_addr);
      end
      tick();
      bus.response_enable = 1;
      bus.resp_data       = 32'hCAFE_0001;
      tick();
      bus.response_enable = 0;
      checks++;
      if (bus.f_resp_en !== 1'b1 || bus.f_resp_data !== 32'hCAFE_0001 || bus.m_resp_en !== 1'b0 ||
          bus.m_resp_data !== 32'h1234_5678) begin
         failures++;
         $display("FAIL simul_route: f_en=%b f_data=%h m_en=%b m_data=%h required 1 cafe0001 0 12345678",
                  bus.f_resp_en, bus.f_resp_data, bus.m_resp_en, bus.m_resp_data);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      set_f(1'b0, 32'h0000_0080);
      tick();
      drive_idle();
      tick();                                  // WAIT
      bus.response_enable = 1;
      bus.resp_data       = 32'hB2B0_0000;
      set_m(1'b0, 32'h0000_0300, 4'hF);
      tick();
      drive_idle();
      checks++;
      if (bus.f_resp_en !== 1'b1 || bus.request_enable !== 1'b1 || bus.req_addr !== 32'h0000_0300) begin
         failures++;
         $display("FAIL b2b_issue: f_en=%b en=%b addr=%h required 1 1 00000300",
                  bus.f_resp_en, bus.request_enable, bus.req_addr);
      end
      drain();
   endtask

   task automatic test_violation();
      set_m(1'b0, 32'h0000_0A00, 4'hF);
      tick();                                  // M issued
      drive_idle();
      set_f(1'b0, 32'h0000_0111);
      tick();                                  // F pending
      set_f(1'b1, 32'h0000_0222);              // refused: F already pending
      tick();
      drive_idle();
      bus.response_enable = 1;
      tick();
      bus.response_enable = 0;
      checks++;
      if (bus.request_enable !== 1'b1 || bus.req_addr !== 32'h0000_0111 || bus.req_mode !== 1'b0) begin
         failures++;
         $display("FAIL viol_pending: en=%b addr=%h mode=%b required 1 00000111 0",
                  bus.request_enable, bus.req_addr, bus.req_mode);
      end
      tick();                                  // F in WAIT
      set_f(1'b0, 32'h0000_0333);              // refused: F owns the port
      tick();
      bus.f_req_en        = 0;
      bus.response_enable = 1;
      tick();
      bus.response_enable = 0;
      checks++;
      if (bus.f_resp_en !== 1'b1 || bus.request_enable !== 1'b0) begin
         failures++;
         $display("FAIL viol_owner: f_en=%b en=%b required 1 0", bus.f_resp_en, bus.request_enable);
      end
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.req_addr !== 32'h0000_0111) begin
         failures++;
         $display("FAIL viol_idle: busy=%b addr=%h required 0 00000111", bus.busy, bus.req_addr);
      end
   endtask

`ifdef MEM_ARB_RR_EN
   task automatic test_round_robin();
      int prev;
      int granted;
      int n;
      prev = rr_last;                          // model's record of the last grant
      set_f(1'b0, 32'hF000_0000);
      set_m(1'b0, 32'hA000_0000, 4'hF);
      for (int k = 0; k < 6; k++) begin
         n = 0;
         while (!bus.request_enable && n < 20) begin
            tick();
            n++;
         end
         checks++;
         if (bus.request_enable !== 1'b1) begin
            failures++;
            $display("FAIL rr_timeout: no request_enable for grant %0d", k);
         end
         granted = (bus.req_addr[31:28] == 4'hF) ? 0 : 1;
         checks++;
         if (granted == prev) begin
            failures++;
            $display("FAIL rr_alternate: grant %0d went to port %0d, required port %0d", k, granted, 1 - prev);
         end
         prev = granted;
         tick();
         drive_idle();
         bus.response_enable = 1;
         tick();
         bus.response_enable = 0;
         if (granted == 0) set_f(1'b0, 32'hF000_0000 + 32'(k + 1));
         else              set_m(1'b0, 32'hA000_0000 + 32'(k + 1), 4'hF);
      end
      drain();
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         bus.f_req_en    = ($urandom_range(0, 3) == 0);
         bus.f_req_mode  = 1'($urandom_range(0, 1));
         bus.f_req_addr  = $urandom;
         bus.f_req_wdata = $urandom;
         bus.f_req_wstrb = 4'($urandom_range(0, 15));
         bus.m_req_en    = ($urandom_range(0, 3) == 0);
         bus.m_req_mode  = 1'($urandom_range(0, 1));
         bus.m_req_addr  = $urandom;
         bus.m_req_wdata = $urandom;
         bus.m_req_wstrb = 4'($urandom_range(0, 15));
         bus.response_enable = ($urandom_range(0, 2) == 0);
         bus.resp_data       = $urandom;
         tick();
         checks++;
         if (bus.request_enable !== e_reqen) begin
            failures++;
            $display("FAIL rand_req_en: cycle %0d got %b required %b", i, bus.request_enable, e_reqen);
         end
         checks++;
         if ({bus.req_mode, bus.req_addr, bus.req_wdata, bus.req_wstrb} !== e_req) begin
            failures++;
            $display("FAIL rand_req_fields: cycle %0d got %h required %h", i,
                     {bus.req_mode, bus.req_addr, bus.req_wdata, bus.req_wstrb}, e_req);
         end
         checks++;
         if (bus.f_resp_en !== e_resp_en[0] || bus.f_resp_data !== e_resp_data[0]) begin
            failures++;
            $display("FAIL rand_f_resp: cycle %0d got %b %h required %b %h", i,
                     bus.f_resp_en, bus.f_resp_data, e_resp_en[0], e_resp_data[0]);
         end
         checks++;
         if (bus.m_resp_en !== e_resp_en[1] || bus.m_resp_data !== e_resp_data[1]) begin
            failures++;
            $display("FAIL rand_m_resp: cycle %0d got %b %h required %b %h", i,
                     bus.m_resp_en, bus.m_resp_data, e_resp_en[1], e_resp_data[1]);
         end
         checks++;
         if (bus.busy !== e_busy()) begin
            failures++;
            $display("FAIL rand_busy: cycle %0d got %b required %b", i, bus.busy, e_busy());
         end
      end
      drain();
   endtask

   task automatic test_reset_mid_wait();
      set_f(1'b1, 32'h0000_0444);
      set_m(1'b0, 32'h0000_0555, 4'hF);
      tick();
      drive_idle();
      tick();                                  // WAIT, F pending
      rstn = 0;
      model_reset();
      #1;
      checks++;
      if (all_outputs() !== '0) begin
         failures++;
         $display("FAIL rst_wait_async: got %h required 0", all_outputs());
      end
      @(negedge clk);
      rstn = 1;
      bus.response_enable = 1;
      bus.resp_data       = 32'h7777_7777;
      tick();
      bus.response_enable = 0;
      tick();
      checks++;
      if (all_outputs() !== '0) begin
         failures++;
         $display("FAIL rst_wait_late_resp: got %h required 0", all_outputs());
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_single_fetch();
      test_simultaneous();
      test_back_to_back();
      test_violation();
`ifdef MEM_ARB_RR_EN
      test_round_robin();
`endif
      test_random();
      test_reset_mid_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
